// File: rtl/tbird_pkg.sv
// tbird_pkg -- shared definitions for the Thunderbird tail-light path.
//   DEBOUNCE_CYCLES_DEF : default debounce length in clk cycles
//   TICK_DIV_DEF        : default clk cycles per FSM step enable
//   req_e               : request encoding shared with the tail-light FSM
//   req_encode()        : maps debounced left/right levels to a request
package tbird_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int TICK_DIV_DEF        = 25000000;

  typedef enum logic [1:0] {
    REQ_OFF    = 2'd0,
    REQ_LEFT   = 2'd1,
    REQ_RIGHT  = 2'd2,
    REQ_HAZARD = 2'd3
  } req_e;

  // Both switches on is a hazard request, never left and right together.
  function automatic req_e req_encode(input logic l, input logic r);
    req_e req;
    case ({l, r})
      2'b10:   req = REQ_LEFT;
      2'b01:   req = REQ_RIGHT;
      2'b11:   req = REQ_HAZARD;
      default: req = REQ_OFF;
    endcase
    return req;
  endfunction

endpackage

// File: rtl/tbird_input_cond_if.sv
// tbird_input_cond_if -- switch pins in, conditioned requests out.
//   left_pin, right_pin : raw turn switches (asynchronous to clk)
//   clk_en              : one-cycle FSM step enable
//   left_req, right_req, hazard_req : mutually exclusive requests
// Modports: master = switch/FSM side, slave = the conditioner.
interface tbird_input_cond_if;
  logic left_pin;
  logic right_pin;
  logic clk_en;
  logic left_req;
  logic right_req;
  logic hazard_req;

  modport master (
    output left_pin, right_pin,
    input  clk_en, left_req, right_req, hazard_req
  );

  modport slave (
    input  left_pin, right_pin,
    output clk_en, left_req, right_req, hazard_req
  );
endinterface

// File: rtl/switch_debounce.sv
// switch_debounce -- two-flop synchroniser plus debounce counter for one
// switch channel.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   pin   : raw switch level (asynchronous to clk)
//   db    : debounced level; follows the synced level only after it has
//           differed for DEBOUNCE_CYCLES consecutive edges
module switch_debounce
  import tbird_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic db
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             db_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      db_reg    <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= pin;
      sync2_reg <= sync1_reg;
      // Any return to the accepted level restarts the count, so a bounce
      // has to settle for the full window before it is believed.
      if (sync2_reg == db_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        db_reg  <= sync2_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign db = db_reg;

endmodule

// File: rtl/tbird_input_cond.sv
// tbird_input_cond -- input conditioner in front of the tail-light FSM.
// Debounces both turn switches, generates the slow step enable and
// presents requests that only change on a step enable.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   io    : tbird_input_cond_if.slave (pins in, clk_en/requests out)
// Build option: SW_ACTIVE_LOW_EN -- pins read 0 when the switch is on
// (pull-up wiring); they are inverted ahead of the synchronisers.
module tbird_input_cond
  import tbird_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int TICK_DIV        = TICK_DIV_DEF
) (
  input logic                 clk,
  input logic                 reset,
  tbird_input_cond_if.slave   io
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  // Channel 0 = left, channel 1 = right.
  logic [1:0] pin_vec;
  logic [1:0] db_vec;

`ifdef SW_ACTIVE_LOW_EN
  // Inverting here keeps every internal level meaning "switch on" = 1,
  // so reset values of 0 still mean "off".
  assign pin_vec = ~{io.right_pin, io.left_pin};
`else
  assign pin_vec = {io.right_pin, io.left_pin};
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .pin  (pin_vec[gi]),
      .db   (db_vec[gi])
    );
  end

  logic [DIV_W-1:0] div_cnt_reg;
  logic             clk_en_reg;
  logic             left_req_reg;
  logic             right_req_reg;
  logic             hazard_req_reg;
  req_e             req_next;

  assign req_next = req_encode(db_vec[0], db_vec[1]);

  // Free-running divider; clk_en is registered so it is high in the cycle
  // after div_cnt hits its terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_reg <= '0;
      clk_en_reg  <= 1'b0;
    end else begin
      clk_en_reg  <= (div_cnt_reg == DIV_MAX);
      div_cnt_reg <= (div_cnt_reg == DIV_MAX) ? '0 : div_cnt_reg + DIV_W'(1);
    end
  end

  // Requests sample the debounced levels only on a step enable, so a db
  // change landing on the same edge is picked up one step later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_req_reg   <= 1'b0;
      right_req_reg  <= 1'b0;
      hazard_req_reg <= 1'b0;
    end else if (clk_en_reg) begin
      left_req_reg   <= (req_next == REQ_LEFT);
      right_req_reg  <= (req_next == REQ_RIGHT);
      hazard_req_reg <= (req_next == REQ_HAZARD);
    end
  end

  assign io.clk_en     = clk_en_reg;
  assign io.left_req   = left_req_reg;
  assign io.right_req  = right_req_reg;
  assign io.hazard_req = hazard_req_reg;

endmodule

// File: tb/tb_tbird_input_cond.sv
// tb_tbird_input_cond -- self-checking bench for tbird_input_cond with
// DEBOUNCE_CYCLES=4, TICK_DIV=8. A reference model built from the pin
// sample history pushes expected outputs into a scoreboard queue at each
// edge; the monitored outputs are popped and compared 1 time unit later.
// Works for both builds (SW_ACTIVE_LOW_EN defined or not).
module tb_tbird_input_cond;
  localparam int DB  = 4;
  localparam int DIV = 8;
  localparam int HW  = DB + 2;

`ifdef SW_ACTIVE_LOW_EN
  localparam logic PIN_INV = 1'b1;
`else
  localparam logic PIN_INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;

  tbird_input_cond_if bus ();

  tbird_input_cond #(
    .DEBOUNCE_CYCLES(DB),
    .TICK_DIV       (DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state. hist holds the logical switch level sampled at
  // each edge, newest in bit 0; the synchronised level seen at edge n is
  // the sample from edge n-2, so db flips once samples n-5..n-2 all differ.
  logic [HW-1:0] hist_l, hist_r;
  logic          db_l_m, db_r_m;
  logic          en_m;
  logic [2:0]    req_m;           // {hazard, right, left}
  int            edge_cnt;
  logic [3:0]    exp_q[$];        // {clk_en, hazard, right, left}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic set_sw(input logic l, input logic r);
    bus.left_pin  = l ^ PIN_INV;
    bus.right_pin = r ^ PIN_INV;
  endtask

  task automatic model_reset();
    hist_l   = '0;
    hist_r   = '0;
    db_l_m   = 1'b0;
    db_r_m   = 1'b0;
    en_m     = 1'b0;
    req_m    = 3'b000;
    edge_cnt = 0;
  endtask

  task automatic model_edge();
    logic [2:0] req_new;
    if (!reset) begin
      model_reset();
    end else begin
      req_new = en_m ? {db_l_m & db_r_m, db_r_m & ~db_l_m, db_l_m & ~db_r_m} : req_m;
      hist_l = {hist_l[HW-2:0], bus.left_pin ^ PIN_INV};
      hist_r = {hist_r[HW-2:0], bus.right_pin ^ PIN_INV};
      if (hist_l[HW-1:2] == {DB{~db_l_m}}) db_l_m = ~db_l_m;
      if (hist_r[HW-1:2] == {DB{~db_r_m}}) db_r_m = ~db_r_m;
      edge_cnt++;
      en_m  = (edge_cnt % DIV == 0);
      req_m = req_new;
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.clk_en, bus.hazard_req, bus.right_req, bus.left_req};
  endfunction

  task automatic run_cycles(input int n);
    logic [3:0] got_v, exp_v;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      exp_q.push_back({en_m, req_m});
      #1;
      got_v = outs();
      exp_v = exp_q.pop_front();
      check_eq("outs", 32'(got_v), 32'(exp_v));
      check_eq("excl", 32'($countones(got_v[2:0]) <= 1), 32'd1);
      if (got_v[3])
        $display("t=%0t step: left=%0b right=%0b hazard=%0b", $time, got_v[0], got_v[1], got_v[2]);
    end
  endtask

  initial begin
    model_reset();
    set_sw(1'b0, 1'b0);

    // 1: reset held, then free-running step enable.
    #2;
    check_eq("rst_outs", 32'(outs()), 32'd0);
    run_cycles(5);
    reset = 1'b1;
    run_cycles(7);
    check_eq("en_before_8", 32'(bus.clk_en), 32'd0);
    run_cycles(1);
    check_eq("en_at_8", 32'(bus.clk_en), 32'd1);
    run_cycles(1);
    check_eq("en_width", 32'(bus.clk_en), 32'd0);
    run_cycles(10);

    // 2: left switch held.
    set_sw(1'b1, 1'b0);
    run_cycles(20);
    check_eq("left_on", 32'(outs() & 4'b0111), 32'b0001);

    // 3: release, then a 3-cycle glitch that must be rejected.
    set_sw(1'b0, 1'b0);
    run_cycles(16);
    set_sw(1'b1, 1'b0);
    run_cycles(3);
    set_sw(1'b0, 1'b0);
    run_cycles(32);
    check_eq("glitch_left", 32'(bus.left_req), 32'd0);

    // 4: hazard, then right released -> left.
    set_sw(1'b1, 1'b1);
    run_cycles(20);
    check_eq("hazard_on", 32'(outs() & 4'b0111), 32'b0100);
    set_sw(1'b1, 1'b0);
    run_cycles(20);
    check_eq("hazard_to_left", 32'(outs() & 4'b0111), 32'b0001);

    // 5: asynchronous reset between edges with left_req active.
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst", 32'(outs()), 32'd0);
    run_cycles(3);
    reset = 1'b1;
    run_cycles(6);
    check_eq("left_relatch_early", 32'(bus.left_req), 32'd0);
    run_cycles(10);
    check_eq("left_relatch", 32'(bus.left_req), 32'd1);

    // 6: right alone, then random bouncing on both pins.
    set_sw(1'b0, 1'b1);
    run_cycles(20);
    check_eq("right_on", 32'(outs() & 4'b0111), 32'b0010);
    for (int s = 0; s < 40; s++) begin
      set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_cycles($urandom_range(1, 14));
    end
    set_sw(1'b0, 1'b0);
    run_cycles(20);
    check_eq("all_off", 32'(outs() & 4'b0111), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
